// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel counters plus hsync/vsync/blank/frame_start strobes.
// Define VGA_SYNC_ALIGN_EN to delay hsync/vsync/blank by one pixel to match a registered colour stage.
module vga_sync_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL < 1 || H_TOTAL > 2048) begin : g_h_total_chk
      $error("vga_sync_gen: H_TOTAL does not fit the 11-bit hcount port");
    end
    if (V_TOTAL < 1 || V_TOTAL > 1024) begin : g_v_total_chk
      $error("vga_sync_gen: V_TOTAL does not fit the 10-bit vcount port");
    end
  endgenerate

  // One extra bit on the boundaries so a zero back porch at the maximum total cannot overflow.
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS  = 12'(H_VISIBLE);
  localparam logic [11:0] H_SS   = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] H_SE   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SS   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SE   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        wrap_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        frame_start_q;
  logic        hs_act_d, vs_act_d;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    wrap_d   = 1'b0;
    if (hcount_q == H_LAST) begin
      hcount_d = 11'd0;
      if (vcount_q == V_LAST) begin
        vcount_d = 10'd0;
        wrap_d   = 1'b1;
      end else begin
        vcount_d = vcount_q + 10'd1;
      end
    end else begin
      hcount_d = hcount_q + 11'd1;
    end
  end

  // Strobes decode the next-state counts so they land in the same cycle as those counts.
  always_comb begin
    hs_act_d = ({1'b0, hcount_d} >= H_SS) && ({1'b0, hcount_d} < H_SE);
    vs_act_d = ({1'b0, vcount_d} >= V_SS) && ({1'b0, vcount_d} < V_SE);
    hsync_d  = hs_act_d ? HS_POL : ~HS_POL;
    vsync_d  = vs_act_d ? VS_POL : ~VS_POL;
    blank_d  = ({1'b0, hcount_d} >= H_VIS) || ({1'b0, vcount_d} >= V_VIS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 10'd0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pix_ce) begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      frame_start_q <= wrap_d;
    end else begin
      frame_start_q <= 1'b0;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic hsync_al_q, vsync_al_q, blank_al_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_al_q <= ~HS_POL;
      vsync_al_q <= ~VS_POL;
      blank_al_q <= 1'b0;
    end else if (pix_ce) begin
      hsync_al_q <= hsync_q;
      vsync_al_q <= vsync_q;
      blank_al_q <= blank_q;
    end
  end

  assign hsync = hsync_al_q;
  assign vsync = vsync_al_q;
  assign blank = blank_al_q;
`else
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign blank = blank_q;
`endif

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_start = frame_start_q;

endmodule
